// File: rtl/plantard_mm_pipe_pkg.sv
// Shared constants and width helpers for the Plantard modular multiplier.
package pmm_pkg;

    localparam int          PMM_Q      = 3329;
    localparam int          PMM_L      = 16;
    localparam int          PMM_ALPHA  = 3;
    localparam int          PMM_DATA_W = 12;
    localparam logic [31:0] PMM_QINV   = 32'd1806234369;

    // (-2^(2L)) mod q: using it as the b operand makes the multiplier return a unchanged.
    function automatic int calc_r_id(input int q, input int l);
        int r;
        r = 1;
        for (int i = 0; i < 2 * l; i++) begin
            r = (r * 2) % q;
        end
        return (q - r) % q;
    endfunction

    localparam int R_ID = calc_r_id(PMM_Q, PMM_L);

    // Width of an unsigned product of two operands.
    function automatic int prod_w(input int wa, input int wb);
        return wa + wb;
    endfunction

endpackage

// File: rtl/plantard_mm_pipe_if.sv
// Streaming valid/ready bus of the Plantard multiplier: operand beats in, result beats out.
interface plantard_mm_pipe_if
    import pmm_pkg::*;
#(
    parameter int LANES  = 1,
    parameter int DATA_W = PMM_DATA_W,
    parameter int TAG_W  = 8
);
    logic                      in_valid;
    logic                      in_ready;
    logic [LANES*DATA_W-1:0]   in_a;
    logic [LANES*DATA_W-1:0]   in_b;
    logic [TAG_W-1:0]          in_tag;
    logic                      out_valid;
    logic                      out_ready;
    logic [LANES*DATA_W-1:0]   out_c;
    logic [TAG_W-1:0]          out_tag;

    modport master (
        output in_valid, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_c, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_c, out_tag
    );
endinterface

// File: rtl/plantard_mm_pipe_lane.sv
// One lane of the Plantard multiplier: product, Plantard low-half multiply, and high-half reduction.
module plantard_lane
    import pmm_pkg::*;
#(
    parameter int             Q      = PMM_Q,
    parameter int             L      = PMM_L,
    parameter int             ALPHA  = PMM_ALPHA,
    parameter int             DATA_W = PMM_DATA_W,
    parameter logic [2*L-1:0] QINV   = PMM_QINV
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              en1_i,
    input  logic              en2_i,
    input  logic              en3_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] c_o
);
    localparam int P_W = prod_w(DATA_W, DATA_W);
    localparam int T_W = 2 * L;
    localparam int U_W = L + 1;
    localparam int M_W = prod_w(U_W, DATA_W);
    localparam logic [M_W-1:0] Q_M = M_W'(Q);

    logic [P_W-1:0]    p_q, p_d;
    logic [T_W-1:0]    t_q, t_d;
    logic [DATA_W-1:0] c_q, c_d;
    logic [U_W-1:0]    u;
    logic [M_W-1:0]    m;

    // Per-stage arithmetic; casting the product to T_W bits gives the mod 2^(2L) reduction directly.
    always_comb begin
        p_d = P_W'(a_i) * P_W'(b_i);
        t_d = T_W'(p_q) * QINV;
        u   = U_W'(t_q >> L) + U_W'(2 ** ALPHA);
        m   = M_W'(u) * Q_M;
        c_d = DATA_W'(m >> L);
    end

    // Stage registers; each advances only when its stage enable is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_q <= '0;
            t_q <= '0;
            c_q <= '0;
        end else begin
            if (en1_i) p_q <= p_d;
            if (en2_i) t_q <= t_d;
            if (en3_i) c_q <= c_d;
        end
    end

    assign c_o = c_q;

endmodule

// File: rtl/plantard_mm_pipe.sv
// Three-stage Plantard multiplier with valid/ready flow control, LANES parallel lanes and a tag.
module plantard_mm_pipe
    import pmm_pkg::*;
#(
    parameter int             Q      = PMM_Q,
    parameter int             L      = PMM_L,
    parameter int             ALPHA  = PMM_ALPHA,
    parameter logic [2*L-1:0] QINV   = PMM_QINV,
    parameter int             DATA_W = PMM_DATA_W,
    parameter int             LANES  = 1,
    parameter int             TAG_W  = 8
)(
    input  logic              clk,
    input  logic              rst,
    plantard_mm_pipe_if.slave bus
);
    logic             v1_q, v2_q, v3_q;
    logic             v1_d, v2_d, v3_d;
    logic [TAG_W-1:0] tag1_q, tag2_q, tag3_q;
    logic [TAG_W-1:0] tag1_d, tag2_d, tag3_d;
    logic             rdy1, rdy2, rdy3;

    // Ready chain: a stage may load when it is empty or its successor is moving on.
    always_comb begin
        rdy3 = !v3_q || bus.out_ready;
        rdy2 = !v2_q || rdy3;
        rdy1 = !v1_q || rdy2;
    end

    // A loading stage takes its predecessor's valid and tag; bubbles are overwritten as they arrive.
    always_comb begin
        v1_d   = rdy1 ? bus.in_valid : v1_q;
        tag1_d = rdy1 ? bus.in_tag   : tag1_q;
        v2_d   = rdy2 ? v1_q         : v2_q;
        tag2_d = rdy2 ? tag1_q       : tag2_q;
        v3_d   = rdy3 ? v2_q         : v3_q;
        tag3_d = rdy3 ? tag2_q       : tag3_q;
    end

    // Valid and tag registers; reset drops every in-flight beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            tag1_q <= '0;
            tag2_q <= '0;
            tag3_q <= '0;
        end else begin
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            v3_q   <= v3_d;
            tag1_q <= tag1_d;
            tag2_q <= tag2_d;
            tag3_q <= tag3_d;
        end
    end

    assign bus.in_ready  = rdy1;
    assign bus.out_valid = v3_q;
    assign bus.out_tag   = tag3_q;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        plantard_lane #(
            .Q      (Q),
            .L      (L),
            .ALPHA  (ALPHA),
            .DATA_W (DATA_W),
            .QINV   (QINV)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .en1_i (rdy1),
            .en2_i (rdy2),
            .en3_i (rdy3),
            .a_i   (bus.in_a[k*DATA_W +: DATA_W]),
            .b_i   (bus.in_b[k*DATA_W +: DATA_W]),
            .c_o   (bus.out_c[k*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_plantard_mm_pipe.sv
// Bench for plantard_mm_pipe: directed vectors plus a modular-arithmetic model and a beat scoreboard.
module tb_plantard_mm_pipe;
    localparam int LANES   = 4;
    localparam int DW      = 12;
    localparam int TW      = 8;
    localparam int Q       = 3329;
    localparam int LAT_OBS = 3;   // handshake cycle of a beat to the cycle its result is first visible

    typedef struct {
        logic [LANES*DW-1:0] a;
        logic [LANES*DW-1:0] b;
        logic [TW-1:0]       tag;
        int                  cyc;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    plantard_mm_pipe_if #(.LANES(LANES), .DATA_W(DW), .TAG_W(TW)) bus ();

    plantard_mm_pipe #(.LANES(LANES), .DATA_W(DW), .TAG_W(TW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int              n_tests = 0;
    int              n_fail  = 0;
    int              cyc     = 0;
    int              inv     = 0;
    beat_t           exp_q[$];
    int              acc_cyc[256];
    int              seen_cyc[256];
    int              seen_cnt[256];
    logic [DW-1:0]   seen_c0[256];
    logic            vhist[4096];
    logic            hold_v = 1'b0;
    logic [LANES*DW-1:0] hold_c;
    logic [TW-1:0]   hold_tag;
    logic            obs_in_ready, obs_out_valid, obs_acc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // c = a*b*(-2^-32) mod Q, i.e. the unique c in [0,Q) with c*1976 = a*b (mod Q).
    function automatic int mm(input int a, input int b);
        return (((a * b) % Q) * inv) % Q;
    endfunction

    // One clock cycle: observe and score at the falling edge, then return just after the rising edge.
    task automatic step();
        beat_t e;
        @(negedge clk);
        obs_in_ready  = bus.in_ready;
        obs_out_valid = bus.out_valid;
        obs_acc       = bus.in_valid && bus.in_ready && !rst;
        if (rst) begin
            exp_q.delete();
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("stall_hold_valid", bus.out_valid, 1);
                check("stall_hold_c", bus.out_c, hold_c);
                check("stall_hold_tag", bus.out_tag, hold_tag);
            end
            if (bus.out_valid && bus.out_ready) begin
                seen_cnt[bus.out_tag]++;
                seen_cyc[bus.out_tag] = cyc;
                seen_c0[bus.out_tag]  = bus.out_c[DW-1:0];
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("tag_order", bus.out_tag, e.tag);
                    check("min_latency", (cyc - e.cyc) >= LAT_OBS, 1);
                    for (int k = 0; k < LANES; k++) begin
                        check("lane_c", bus.out_c[k*DW +: DW],
                              mm(int'(e.a[k*DW +: DW]), int'(e.b[k*DW +: DW])));
                    end
                end
            end
            hold_v   = bus.out_valid && !bus.out_ready;
            hold_c   = bus.out_c;
            hold_tag = bus.out_tag;
            if (obs_acc) begin
                e.a   = bus.in_a;
                e.b   = bus.in_b;
                e.tag = bus.in_tag;
                e.cyc = cyc;
                exp_q.push_back(e);
                acc_cyc[bus.in_tag] = cyc;
            end
        end
        if (cyc < 4096) vhist[cyc] = bus.out_valid;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int k, input int a, input int b);
        bus.in_a[k*DW +: DW] = DW'(a);
        bus.in_b[k*DW +: DW] = DW'(b);
    endtask

    initial begin
        int vals[5];
        int ca[4];
        int cb[4];
        int cexp[4];
        int pat[6];
        int idx, ovcnt, full_idx, c0, j, sent, guard;

        vals = '{190, 2002, 3015, 484, 1938};
        ca   = '{0, 3328, 1, 3328};
        cb   = '{2285, 1976, 1976, 3328};
        cexp = '{0, 3328, 1, 1400};
        pat  = '{1, 0, 1, 0, 0, 1};

        for (int x = 1; x < Q; x++) if ((x * 1976) % Q == 1) inv = x;
        foreach (seen_cnt[i]) begin
            seen_cnt[i] = 0; seen_cyc[i] = 0; acc_cyc[i] = 0; seen_c0[i] = '0;
        end
        foreach (vhist[i]) vhist[i] = 1'b0;

        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_tag = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_out_c", bus.out_c, 0);
        check("reset_out_tag", bus.out_tag, 0);
        check("reset_in_ready", bus.in_ready, 1);
        check("model_inverse", inv, 1400);

        // Identity stream: b = 1976 returns a.
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            for (int k = 0; k < LANES; k++) set_lane(k, vals[(i + k) % 5], 1976);
            bus.in_tag = TW'(i);
            step();
        end
        bus.in_valid = 1'b0;
        repeat (6) step();
        for (int i = 0; i < 5; i++) begin
            check("identity_c0", seen_c0[i], vals[i]);
            check("identity_count", seen_cnt[i], 1);
            check("identity_latency", seen_cyc[i] - acc_cyc[i], LAT_OBS);
            if (i > 0) check("identity_back_to_back", seen_cyc[i] - seen_cyc[i-1], 1);
        end

        // Corner operands.
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            set_lane(0, ca[i], cb[i]);
            for (int k = 1; k < LANES; k++) set_lane(k, (ca[i] + 777 * k) % Q, cb[i]);
            bus.in_tag = TW'(50 + i);
            step();
        end
        bus.in_valid = 1'b0;
        repeat (6) step();
        for (int i = 0; i < 4; i++) check("corner_c0", seen_c0[50 + i], cexp[i]);

        // Backpressure: hold out_ready low for the first 4 cycles of output.
        idx = 0; ovcnt = 0; full_idx = -1;
        for (int c = 0; c < 24; c++) begin
            bus.in_valid = (idx < 6);
            for (int k = 0; k < LANES; k++) set_lane(k, (idx * 611 + k * 97) % Q, 2285);
            bus.in_tag    = TW'(20 + idx);
            bus.out_ready = (ovcnt >= 4);
            step();
            if (obs_out_valid && ovcnt < 4) ovcnt++;
            if (!obs_in_ready && full_idx < 0) full_idx = idx;
            if (obs_acc) idx++;
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        repeat (4) step();
        check("bp_full_at_three", full_idx, 3);
        check("bp_first_delay", seen_cyc[20] - acc_cyc[20], LAT_OBS + 4);
        for (int t = 0; t < 6; t++) begin
            check("bp_count", seen_cnt[20 + t], 1);
            if (t > 0) check("bp_order", seen_cyc[20 + t] > seen_cyc[19 + t], 1);
        end

        // Bubbles: the in_valid pattern reappears on out_valid three cycles later.
        c0 = cyc; j = 0;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = pat[i][0];
            for (int k = 0; k < LANES; k++) set_lane(k, 100 + 13 * i + k, 1976);
            bus.in_tag = TW'(10 + j);
            if (pat[i] != 0) j++;
            step();
        end
        bus.in_valid = 1'b0;
        repeat (6) step();
        check("bubble_before", vhist[c0 + LAT_OBS - 1], 0);
        for (int i = 0; i < 6; i++) check("bubble_pattern", vhist[c0 + LAT_OBS + i], pat[i]);

        // Reset with two beats in flight.
        bus.in_valid = 1'b1;
        for (int k = 0; k < LANES; k++) set_lane(k, 1234 + k, 2000);
        bus.in_tag = 8'd40;
        step();
        bus.in_tag = 8'd41;
        step();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midreset_out_valid", bus.out_valid, 0);
        check("midreset_out_c", bus.out_c, 0);
        check("midreset_in_ready", bus.in_ready, 1);
        repeat (8) step();
        check("midreset_drop_40", seen_cnt[40], 0);
        check("midreset_drop_41", seen_cnt[41], 0);

        // Random traffic on all lanes.
        sent = 0; guard = 0;
        while (sent < 10000 && guard < 40000) begin
            bus.in_valid = ($urandom_range(0, 9) < 7);
            for (int k = 0; k < LANES; k++)
                set_lane(k, int'($urandom_range(0, Q - 1)), int'($urandom_range(0, Q - 1)));
            bus.in_tag    = TW'(sent);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            step();
            guard++;
            if (obs_acc) sent++;
        end
        check("random_sent", sent, 10000);
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        repeat (8) step();
        check("drain_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
